// File: rtl/branch_predictor_param.sv
// branch_predictor_param
//
// Parametrised branch direction predictor: a table of 2^ENTRY_BITS saturating
// counters indexed by PC (MODE 0), PC xor global history (MODE 1) or global
// history alone (MODE 2). Builds in resolved-branch / correct-prediction
// statistics.
//
// After reset the table is swept to "weakly not-taken", one entry per cycle
// (INIT). During INIT, lookups answer not-taken and updates are dropped. Once
// the sweep finishes the block stays in RUN until the next reset.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   lookup_valid/pc   prediction request from IF
//   pred_valid/taken/index   registered prediction, one cycle after lookup
//   update_valid/index/taken/pred   resolved branch from the back end
//   clear_stats       synchronous clear of the statistics counters
//   ready             table sweep finished
//   branch_count, correct_count   saturating statistics
module branch_predictor_param #(
  parameter int ENTRY_BITS = 12,
  parameter int HIST_BITS  = 12,
  parameter int CTR_BITS   = 2,
  parameter int MODE       = 1,
  parameter int PC_LSB     = 2,
  parameter int STAT_BITS  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_valid,
  input  logic [31:0]           lookup_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [ENTRY_BITS-1:0] pred_index,
  input  logic                  update_valid,
  input  logic [ENTRY_BITS-1:0] update_index,
  input  logic                  update_taken,
  input  logic                  update_pred,
  input  logic                  clear_stats,
  output logic                  ready,
  output logic [STAT_BITS-1:0]  branch_count,
  output logic [STAT_BITS-1:0]  correct_count
);

  localparam int ENTRIES = 1 << ENTRY_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

  typedef enum logic {INIT, RUN} state_t;

  state_t                state_q, state_d;
  logic [ENTRY_BITS-1:0] ptr_q, ptr_d;
  logic [HIST_BITS-1:0]  ghr_q, ghr_d, ghr_shift;
  logic [CTR_BITS-1:0]   table_q [ENTRIES];

  logic [ENTRY_BITS-1:0] ghr_ext, pc_idx, lookup_idx;
  logic [CTR_BITS-1:0]   upd_ctr, upd_ctr_next;
  logic [STAT_BITS-1:0]  branch_d, correct_d;
  logic                  run, upd_en;

  assign run    = (state_q == RUN);
  assign upd_en = run && update_valid;
  assign ready  = run;
  assign pc_idx = lookup_pc[PC_LSB +: ENTRY_BITS];

  // History is truncated or zero-extended to the index width.
  if (HIST_BITS >= ENTRY_BITS) begin : g_ghr_trunc
    assign ghr_ext = ghr_q[ENTRY_BITS-1:0];
  end else begin : g_ghr_zext
    assign ghr_ext = {{(ENTRY_BITS-HIST_BITS){1'b0}}, ghr_q};
  end

  if (HIST_BITS == 1) begin : g_ghr_one
    assign ghr_shift = update_taken;
  end else begin : g_ghr_many
    assign ghr_shift = {ghr_q[HIST_BITS-2:0], update_taken};
  end

  // Lookup pc bits outside the index field, and history bits beyond it, are
  // intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{lookup_pc, ghr_q};

  always_comb begin
    if (MODE == 1)      lookup_idx = pc_idx ^ ghr_ext;
    else if (MODE == 2) lookup_idx = ghr_ext;
    else                lookup_idx = pc_idx;
  end

  // Sweep control and history/statistics next-state.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ghr_d     = ghr_q;
    branch_d  = branch_count;
    correct_d = correct_count;

    if (state_q == INIT) begin
      ptr_d = ptr_q + ENTRY_BITS'(1);
      if (ptr_q == {ENTRY_BITS{1'b1}}) state_d = RUN;
    end

    if (upd_en) begin
      ghr_d = ghr_shift;
      if (branch_count != {STAT_BITS{1'b1}})
        branch_d = branch_count + STAT_BITS'(1);
      if ((update_pred == update_taken) && (correct_count != {STAT_BITS{1'b1}}))
        correct_d = correct_count + STAT_BITS'(1);
    end

    // Clear beats a coincident update; the table and history still move.
    if (clear_stats) begin
      branch_d  = '0;
      correct_d = '0;
    end
  end

  // Saturating read-modify-write of the addressed counter.
  always_comb begin
    upd_ctr      = table_q[update_index];
    upd_ctr_next = upd_ctr;
    if (update_taken) begin
      if (upd_ctr != CTR_MAX) upd_ctr_next = upd_ctr + CTR_BITS'(1);
    end else begin
      if (upd_ctr != '0)      upd_ctr_next = upd_ctr - CTR_BITS'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; that is what gives read-before-write on a
  // same-cycle lookup and update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= INIT;
      ptr_q         <= '0;
      ghr_q         <= '0;
      branch_count  <= '0;
      correct_count <= '0;
      pred_valid    <= 1'b0;
      pred_taken    <= 1'b0;
      pred_index    <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      ghr_q         <= ghr_d;
      branch_count  <= branch_d;
      correct_count <= correct_d;
      pred_valid    <= lookup_valid;
      if (lookup_valid) begin
        pred_index <= lookup_idx;
        pred_taken <= run & table_q[lookup_idx][CTR_BITS-1];
      end
    end
  end

  // NOTE: the counter table has no reset; the INIT sweep initialises it, which
  // keeps it mappable to plain RAM and avoids a 2^ENTRY_BITS-wide reset fan-out.
  always_ff @(posedge clk) begin
    if (!run)              table_q[ptr_q]        <= CTR_INIT;
    else if (update_valid) table_q[update_index] <= upd_ctr_next;
  end

endmodule

// File: tb/tb_branch_predictor_param.sv
// Testbench for branch_predictor_param. Three instances with ENTRY_BITS=4,
// STAT_BITS=4 share one stimulus stream: MODE 0 (HIST 4, 2-bit counters),
// MODE 1 (HIST 4, 2-bit counters) and MODE 2 (HIST 6, 3-bit counters).
// A behavioural model (plain integer arrays) predicts every output; a table of
// hand-derived vectors covers the directed scenarios.
module tb_branch_predictor_param;

  localparam int N = 3;
  localparam int MODE_A [N] = '{0, 1, 2};
  localparam int HIST_A [N] = '{4, 4, 6};
  localparam int CTR_A  [N] = '{2, 2, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        update_valid;
  logic [3:0]  update_index;
  logic        update_taken;
  logic        update_pred;
  logic        clear_stats;

  logic       pv  [N];
  logic       pt  [N];
  logic [3:0] pi  [N];
  logic       rdy [N];
  logic [3:0] bc  [N];
  logic [3:0] cc  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    branch_predictor_param #(
      .ENTRY_BITS(4), .HIST_BITS(HIST_A[g]), .CTR_BITS(CTR_A[g]),
      .MODE(MODE_A[g]), .PC_LSB(2), .STAT_BITS(4)
    ) u_dut (
      .clk(clk), .rst(rst),
      .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .pred_valid(pv[g]), .pred_taken(pt[g]), .pred_index(pi[g]),
      .update_valid(update_valid), .update_index(update_index),
      .update_taken(update_taken), .update_pred(update_pred),
      .clear_stats(clear_stats), .ready(rdy[g]),
      .branch_count(bc[g]), .correct_count(cc[g])
    );
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_tbl [N][16];
  int m_ghr [N];
  int m_bc  [N];
  int m_cc  [N];
  int m_cyc;            // rising edges since reset release

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      for (int e = 0; e < 16; e++) m_tbl[i][e] = (1 << (CTR_A[i] - 1)) - 1;
      m_ghr[i] = 0;
      m_bc[i]  = 0;
      m_cc[i]  = 0;
    end
    m_cyc = 0;
  endfunction

  // One clock: drive at the falling edge, advance the model, sample at the
  // next falling edge and compare every instance.
  task automatic step(input logic lv, input logic [31:0] pc, input logic uv,
                      input logic [3:0] ui, input logic ut, input logic up,
                      input logic cs);
    int e_t [N];
    int e_i [N];
    int run_now;
    lookup_valid = lv;  lookup_pc   = pc;
    update_valid = uv;  update_index = ui;
    update_taken = ut;  update_pred  = up;
    clear_stats  = cs;

    run_now = (m_cyc >= 16);
    for (int i = 0; i < N; i++) begin
      int pc_idx;
      int gh;
      int maxc;
      pc_idx = int'(pc >> 2) & 15;
      gh     = m_ghr[i] & 15;
      maxc   = (1 << CTR_A[i]) - 1;
      case (MODE_A[i])
        0:       e_i[i] = pc_idx;
        1:       e_i[i] = pc_idx ^ gh;
        default: e_i[i] = gh;
      endcase
      e_t[i] = (run_now != 0 && m_tbl[i][e_i[i]] >= (1 << (CTR_A[i] - 1))) ? 1 : 0;
      if (run_now != 0 && uv) begin
        if (ut) m_tbl[i][ui] = (m_tbl[i][ui] < maxc) ? m_tbl[i][ui] + 1 : maxc;
        else    m_tbl[i][ui] = (m_tbl[i][ui] > 0)    ? m_tbl[i][ui] - 1 : 0;
        m_ghr[i] = ((m_ghr[i] << 1) | int'(ut)) & ((1 << HIST_A[i]) - 1);
        if (m_bc[i] < 15) m_bc[i]++;
        if (up == ut && m_cc[i] < 15) m_cc[i]++;
      end
      if (cs) begin
        m_bc[i] = 0;
        m_cc[i] = 0;
      end
    end
    if (m_cyc < 16) m_cyc++;

    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("pred_valid[%0d]", i), int'(pv[i]), int'(lv));
      if (lv) begin
        check($sformatf("pred_taken[%0d]", i), int'(pt[i]), e_t[i]);
        check($sformatf("pred_index[%0d]", i), int'(pi[i]), e_i[i]);
      end
      check($sformatf("ready[%0d]", i), int'(rdy[i]), (m_cyc >= 16) ? 1 : 0);
      check($sformatf("branch_count[%0d]", i), int'(bc[i]), m_bc[i]);
      check($sformatf("correct_count[%0d]", i), int'(cc[i]), m_cc[i]);
    end
  endtask

  // Entered at a falling edge; leaves with reset released at a falling edge.
  task automatic do_reset();
    rst = 1'b0;
    lookup_valid = 1'b0; update_valid = 1'b0; clear_stats = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_pred_valid[%0d]", i), int'(pv[i]), 0);
      check($sformatf("rst_pred_taken[%0d]", i), int'(pt[i]), 0);
      check($sformatf("rst_pred_index[%0d]", i), int'(pi[i]), 0);
      check($sformatf("rst_ready[%0d]", i), int'(rdy[i]), 0);
      check($sformatf("rst_branch_count[%0d]", i), int'(bc[i]), 0);
      check($sformatf("rst_correct_count[%0d]", i), int'(cc[i]), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Lookups and update pulses during INIT; ready must rise on edge 16.
  task automatic wait_ready(input string name);
    int first;
    first = 0;
    for (int n = 1; n <= 40 && first == 0; n++) begin
      step(1'b1, $urandom, 1'b1, 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      if (rdy[0] === 1'b1) first = n;
    end
    check(name, first, 16);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        lv;
    logic [31:0] pc;
    logic        uv;
    logic [3:0]  ui;
    logic        ut;
    logic        up;
    logic        cs;
    logic        chk_pred;
    logic        e_t0;     // pred_taken of the MODE 0 instance
    logic [3:0]  e_i1;     // pred_index of the MODE 1 instance
    logic        chk_stats;
    int          e_bc;
    int          e_cc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic lv, logic [31:0] pc, logic uv, logic [3:0] ui,
                              logic ut, logic up, logic cs, logic chk_pred,
                              logic e_t0, logic [3:0] e_i1, logic chk_stats,
                              int e_bc, int e_cc);
    vec_t v;
    v.lv = lv; v.pc = pc; v.uv = uv; v.ui = ui; v.ut = ut; v.up = up; v.cs = cs;
    v.chk_pred = chk_pred; v.e_t0 = e_t0; v.e_i1 = e_i1;
    v.chk_stats = chk_stats; v.e_bc = e_bc; v.e_cc = e_cc;
    return v;
  endfunction

  initial begin
    // Fresh table: counters 01, GHR 0, statistics 0.
    vecs.push_back(mk(1, 32'h14, 0, 0, 0, 0, 0, 1, 0, 4'd5,  1, 0, 0));
    // T,T to idx 5, N to idx 9, T to idx 5 -> GHR 1101, ctr[5] 01->10->11->11
    vecs.push_back(mk(0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 5, 1, 1, 0, 0, 0, 0, 1, 4, 3));
    vecs.push_back(mk(1, 32'h0C, 0, 0, 0, 0, 0, 1, 0, 4'b1110, 0, 0, 0));
    vecs.push_back(mk(1, 32'h14, 0, 0, 0, 0, 0, 1, 1, 4'd8,  0, 0, 0));
    // Four not-taken to idx 5 -> 00; GHR shifts back to 0000.
    for (int k = 0; k < 4; k++) vecs.push_back(mk(0, 0, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h14, 0, 0, 0, 0, 0, 1, 0, 4'd5,  1, 8, 3));
    // Same-cycle lookup and taken update of idx 2: old counter and old GHR seen.
    vecs.push_back(mk(1, 32'h08, 1, 2, 1, 0, 0, 1, 0, 4'd2,  1, 9, 3));
    vecs.push_back(mk(1, 32'h08, 0, 0, 0, 0, 0, 1, 1, 4'd3,  0, 0, 0));
    // Back-to-back taken updates to idx 7, then one not-taken: 01->10->11->10.
    vecs.push_back(mk(0, 0, 1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1C, 0, 0, 0, 0, 0, 1, 1, 4'd9,  1, 12, 6));
    // Clear alone, then 10 updates with 7 correct, then clear with an 11th.
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(0, 0, 1, 12, 1, (k < 7) ? 1'b1 : 1'b0, 0, 0, 0, 0,
                        (k == 9) ? 1'b1 : 1'b0, 10, 7));
    vecs.push_back(mk(0, 0, 1, 12, 1, 1, 1, 0, 0, 0, 1, 0, 0));
    // The cleared update still trained idx 12 and shifted the GHR (1111).
    vecs.push_back(mk(1, 32'h30, 0, 0, 0, 0, 0, 1, 1, 4'd3,  1, 0, 0));

    rst = 1'b1;
    lookup_valid = 1'b0; lookup_pc = '0; update_valid = 1'b0; update_index = '0;
    update_taken = 1'b0; update_pred = 1'b0; clear_stats = 1'b0;
    @(negedge clk);

    do_reset();
    wait_ready("ready_rise_first");

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].lv, vecs[k].pc, vecs[k].uv, vecs[k].ui, vecs[k].ut,
           vecs[k].up, vecs[k].cs);
      if (vecs[k].chk_pred) begin
        check($sformatf("vec%0d_taken_m0", k), int'(pt[0]), int'(vecs[k].e_t0));
        check($sformatf("vec%0d_index_m1", k), int'(pi[1]), int'(vecs[k].e_i1));
      end
      if (vecs[k].chk_stats) begin
        check($sformatf("vec%0d_branch_count", k), int'(bc[0]), vecs[k].e_bc);
        check($sformatf("vec%0d_correct_count", k), int'(cc[0]), vecs[k].e_cc);
      end
    end

    // Reset mid-RUN after training; updates during INIT must be ignored.
    do_reset();
    wait_ready("ready_rise_after_run_reset");
    step(1'b1, 32'h30, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("reinit_taken_m0", int'(pt[0]), 0);
    check("reinit_index_m1", int'(pi[1]), 12);
    check("reinit_index_m2", int'(pi[2]), 0);
    check("reinit_branch_count", int'(bc[0]), 0);
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 32'(k * 4), 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      check($sformatf("reinit_entry%0d_m0", k), int'(pt[0]), 0);
    end

    // Statistics saturate at 15 with STAT_BITS=4.
    for (int k = 0; k < 20; k++) step(1'b0, 32'h0, 1'b1, 4'(k), 1'b1, 1'b1, 1'b0);
    check("sat_branch_count", int'(bc[0]), 15);
    check("sat_correct_count", int'(cc[0]), 15);

    // Reset in the middle of INIT restarts the sweep from entry 0.
    do_reset();
    for (int k = 0; k < 7; k++) step(1'b1, $urandom, 1'b1, 4'($urandom), 1'b1, 1'b0, 1'b0);
    do_reset();
    wait_ready("ready_rise_after_init_reset");

    // Random traffic against the model, with one reset part-way through.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        do_reset();
      end
      step(1'($urandom), $urandom, 1'($urandom), 4'($urandom), 1'($urandom),
           1'($urandom), ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor_param.md
# branch_predictor_param

Parametrised branch direction predictor for the pipelined core. It generalises the fixed 4096-entry local and global predictors into one block with selectable indexing mode, configurable table depth, history length and counter width. It also carries built-in branch and correct-prediction statistics that the bench reads at exit. It sits beside the IF stage: IF issues lookups, and the resolving stage returns outcomes.

## Interface
- ENTRY_BITS, 12: log2 of table entries (4096 by default).
- HIST_BITS, 12: global history register (GHR) width; 1..32.
- CTR_BITS, 2: saturating counter width; 2..4.
- MODE, 1: index mode. 0 = local/bimodal (PC only), 1 = gshare (PC xor GHR), 2 = global (GHR only).
- PC_LSB, 2: lowest PC bit used for indexing.
- STAT_BITS, 32: width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- lookup_valid  in  1  IF requests a prediction this cycle.
- lookup_pc  in  32  PC of the fetched instruction.
- pred_valid  out  1  registered; pred_taken and pred_index are valid.
- pred_taken  out  1  registered predicted direction.
- pred_index  out  ENTRY_BITS  registered table index used; the pipeline carries it to resolve.
- update_valid  in  1  a branch resolved this cycle.
- update_index  in  ENTRY_BITS  pred_index returned from the pipeline.
- update_taken  in  1  actual direction.
- update_pred  in  1  direction that was predicted for this branch.
- clear_stats  in  1  synchronous clear of the statistics counters.
- ready  out  1  table initialisation complete.
- branch_count  out  STAT_BITS  resolved branches counted.
- correct_count  out  STAT_BITS  correctly predicted branches.

## Operation
- Table: 2^ENTRY_BITS counters, each CTR_BITS wide. Predict taken iff the counter MSB is 1.
- Init value of every counter is 2^(CTR_BITS-1)-1, i.e. weakly not-taken (01 for 2-bit counters).
- FSM has two states, INIT and RUN.
  - Reset forces INIT with the sweep pointer at 0.
  - INIT writes the init value to one entry per cycle, pointer 0 to 2^ENTRY_BITS-1.
  - After the last entry the FSM moves to RUN and never leaves it except by reset.
  - A reset asserted mid-INIT or mid-RUN restarts INIT from entry 0.
- Index computation, where pc_idx = lookup_pc[PC_LSB+ENTRY_BITS-1:PC_LSB]:
  - MODE 0: pc_idx.
  - MODE 1: pc_idx xor GHR, with GHR truncated or zero-extended to ENTRY_BITS.
  - MODE 2: GHR truncated or zero-extended to ENTRY_BITS.
- Update in RUN when update_valid is high:
  - The counter at update_index increments if taken, saturating at 2^CTR_BITS-1.
  - It decrements if not taken, saturating at 0.
  - The GHR becomes {GHR[HIST_BITS-2:0], update_taken}. The GHR is non-speculative.
- Statistics, on each update_valid in RUN:
  - branch_count increments by 1.
  - correct_count increments by 1 if update_pred == update_taken.
  - Both counters saturate at all-ones; they never wrap.
- clear_stats zeroes both counters. When it coincides with an update, clear wins: the count for that update is lost, but the table and GHR still update.
- In INIT:
  - Lookups return pred_valid=1 with pred_taken=0 and pred_index = the computed index.
  - update_valid is ignored completely: no table, GHR or statistics change.

## Timing
- Reset values: pred_valid=0, pred_taken=0, pred_index=0, ready=0, branch_count=0, correct_count=0, GHR=0.
- ready rises on the edge that completes the final INIT write, exactly 2^ENTRY_BITS cycles after rst deasserts. It is registered.
- Lookup latency is 1 cycle. A lookup in cycle N gives pred_* in cycle N+1. pred_valid equals lookup_valid delayed by one cycle.
- Same-cycle lookup and update:
  - The lookup sees the pre-update GHR and the pre-update counter, including when the indices match (read-before-write).
  - The update becomes visible to a lookup in cycle N+1.
- Back-to-back updates to the same index on consecutive cycles both take effect, with no lost increment.
- Statistics outputs reflect an update one cycle after update_valid.
- Updates are not queued; the block never stalls.

## Test plan
- Reset with ENTRY_BITS=4 -> ready=0 for 16 cycles and rises at cycle 16. A lookup at any PC then gives pred_taken=0. Both statistics counters read 0.
- MODE 0, CTR_BITS=2: three taken updates to index 5 -> the counter goes 01→10→11→11. Lookup PC 0x14 gives pred_taken=1. Four not-taken updates then give counter 00 and pred_taken=0.
- MODE 1, HIST_BITS=4: updates taken, taken, not-taken, taken -> GHR=4'b1101. Lookup PC 0x0C (pc_idx 3) gives pred_index=4'b1110.
- Same-cycle lookup and update of index 2, where the counter is 01 and the update is taken -> pred_taken=0 in the next cycle. A lookup one cycle later gives pred_taken=1.
- 10 updates with update_pred matching on 7 -> branch_count=10, correct_count=7. clear_stats together with an 11th update -> both read 0.
- Reset mid-RUN after training, then update_valid pulsed during INIT -> table re-initialised, GHR=0, statistics 0. The INIT-time updates change nothing. With STAT_BITS=4, 20 updates give branch_count=15 (saturated).
